// File: rtl/bcd_sub_seq.sv
// bcd_sub_seq: sequential two-digit BCD subtractor, A1A0 - B1B0, one digit per clock.
// Optional input checking is enabled with the macro BCD_SUB_CHECK_EN.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             request, sampled only while idle
//   A1, A0, B1, B0    minuend / subtrahend digits (tens, units)
//   busy, done        handshake; done is a one-cycle pulse with the result valid
//   d1, d0, neg       result digits and sign, held until the next accepted start
//   err               (BCD_SUB_CHECK_EN only) an operand digit was above 9
module bcd_sub_seq #(
  parameter int unsigned MAGNITUDE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A1,
  input  logic [3:0] A0,
  input  logic [3:0] B1,
  input  logic [3:0] B0,
  output logic       busy,
  output logic       done,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       neg
`ifdef BCD_SUB_CHECK_EN
  ,
  output logic       err
`endif
);

  localparam int unsigned DW = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUB0 = 3'd1,
    S_SUB1 = 3'd2,
    S_FIX0 = 3'd3,
    S_FIX1 = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
  logic          bor_q, bor_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] d1_q, d1_d, d0_q, d0_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;

  logic [DW-1:0] step_x, step_y;
  logic          step_bin;
  logic [DW:0]   step_diff, step_adj;
  logic [DW-1:0] step_digit;
  logic          step_bout;
  logic          op_bad;

  // Operand validity check at acceptance time
`ifdef BCD_SUB_CHECK_EN
  assign op_bad = (A1 > 4'd9) || (A0 > 4'd9) || (B1 > 4'd9) || (B0 > 4'd9);
`else
  assign op_bad = 1'b0;
`endif

  // State and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a1_q    <= '0;
      a0_q    <= '0;
      b1_q    <= '0;
      b0_q    <= '0;
      bor_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d1_q    <= '0;
      d0_q    <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      b1_q    <= b1_d;
      b0_q    <= b0_d;
      bor_q   <= bor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  // Shared digit subtractor; the FIX states compute 0 - previous result (ten's complement)
  always_comb begin
    step_x   = '0;
    step_y   = '0;
    step_bin = 1'b0;
    case (state_q)
      S_SUB0: begin
        step_x = a0_q;
        step_y = b0_q;
      end
      S_SUB1: begin
        step_x   = a1_q;
        step_y   = b1_q;
        step_bin = bor_q;
      end
      S_FIX0: step_y = d0_q;
      S_FIX1: begin
        step_y   = d1_q;
        step_bin = bor_q;
      end
      default: ;
    endcase
    step_diff  = {1'b0, step_x} - {1'b0, step_y} - {{DW{1'b0}}, step_bin};
    step_adj   = step_diff + 5'd10;
    step_bout  = step_diff[DW];
    step_digit = step_bout ? step_adj[DW-1:0] : step_diff[DW-1:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = op_bad ? S_DONE : S_SUB0;
      S_SUB0:  state_d = S_SUB1;
      S_SUB1:  state_d = (step_bout && (MAGNITUDE != 0)) ? S_FIX0 : S_DONE;
      S_FIX0:  state_d = S_FIX1;
      S_FIX1:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register updates per state; results hold unless a state writes them
  always_comb begin
    a1_d   = a1_q;
    a0_d   = a0_q;
    b1_d   = b1_q;
    b0_d   = b0_q;
    bor_d  = bor_q;
    busy_d = busy_q;
    done_d = 1'b0;
    d1_d   = d1_q;
    d0_d   = d0_q;
    neg_d  = neg_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a1_d   = A1;
          a0_d   = A0;
          b1_d   = B1;
          b0_d   = B0;
          busy_d = 1'b1;
          err_d  = op_bad;
          if (op_bad) begin
            d1_d  = '0;
            d0_d  = '0;
            neg_d = 1'b0;
          end
        end
      end
      S_SUB0: begin
        d0_d  = step_digit;
        bor_d = step_bout;
      end
      S_SUB1: begin
        d1_d  = step_digit;
        neg_d = step_bout;
      end
      S_FIX0: begin
        d0_d  = step_digit;
        bor_d = step_bout;
      end
      S_FIX1: d1_d = step_digit;
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d1   = d1_q;
  assign d0   = d0_q;
  assign neg  = neg_q;
`ifdef BCD_SUB_CHECK_EN
  assign err  = err_q;
`else
  // err_q is held at its reset value when checking is compiled out
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
